// File: rtl/bram_sdp_fifo_ctrl_if.sv
// ============================================================================
// Module      : bram_sdp_fifo_ctrl_if
// Description : Stream and RAM-port bundle for bram_sdp_fifo_ctrl.
//               BRAM_FIFO_ERR_FLAGS_EN adds the overflow_o/underflow_o flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_sdp_fifo_ctrl_if #(
    parameter int CFG_ABITS = 10,
    parameter int CFG_DBITS = 18
);
    logic                 push_i;
    logic [CFG_DBITS-1:0] wdata_i;
    logic                 full_o;
    logic                 almost_full_o;
    logic                 pop_i;
    logic [CFG_DBITS-1:0] rdata_o;
    logic                 rvalid_o;
    logic                 empty_o;
    logic [CFG_ABITS:0]   count_o;
    logic [CFG_ABITS-1:0] ram_waddr_o;
    logic [CFG_DBITS-1:0] ram_wdata_o;
    logic                 ram_wen_o;
    logic [1:0]           ram_be_o;
    logic [CFG_ABITS-1:0] ram_raddr_o;
    logic                 ram_ren_o;
    logic [CFG_DBITS-1:0] ram_rdata_i;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    logic                 overflow_o;
    logic                 underflow_o;
`endif

    modport master (
        output push_i, wdata_i, pop_i, ram_rdata_i,
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        input  overflow_o, underflow_o,
`endif
        input  full_o, almost_full_o, rdata_o, rvalid_o, empty_o, count_o,
        input  ram_waddr_o, ram_wdata_o, ram_wen_o, ram_be_o, ram_raddr_o, ram_ren_o
    );

    modport slave (
        input  push_i, wdata_i, pop_i, ram_rdata_i,
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        output overflow_o, underflow_o,
`endif
        output full_o, almost_full_o, rdata_o, rvalid_o, empty_o, count_o,
        output ram_waddr_o, ram_wdata_o, ram_wen_o, ram_be_o, ram_raddr_o, ram_ren_o
    );
endinterface

`default_nettype wire

// File: rtl/bram_sdp_fifo_ctrl.sv
// ============================================================================
// Module      : bram_sdp_fifo_ctrl
// Description : Synchronous FIFO controller for one 18-bit SDP BRAM half.
//               Optional macro BRAM_FIFO_ERR_FLAGS_EN adds sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sdp_fifo_ctrl #(
    parameter int CFG_ABITS    = 10,
    parameter int CFG_DBITS    = 18,
    parameter int AFULL_THRESH = 2**CFG_ABITS - 4
) (
    input  wire logic           clock_i,
    input  wire logic           reset_n_i,
    bram_sdp_fifo_ctrl_if.slave bus
);
    localparam logic [CFG_ABITS:0] C_PTR_ONE   = {{CFG_ABITS{1'b0}}, 1'b1};
    localparam logic [CFG_ABITS:0] C_AFULL_LVL = (CFG_ABITS+1)'(AFULL_THRESH);

    logic [CFG_ABITS:0]   r_wr_ptr;
    logic [CFG_ABITS:0]   r_rd_ptr;
    logic                 r_rvalid;
    logic [CFG_ABITS:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_acc;
    logic                 w_pop_acc;
    logic [CFG_DBITS-1:0] w_wdata;
    logic [CFG_DBITS-1:0] w_rdata;

    // Wrap bit distinguishes full from empty when the low address bits match.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[CFG_ABITS-1:0] == r_rd_ptr[CFG_ABITS-1:0]) &&
                     (r_wr_ptr[CFG_ABITS] != r_rd_ptr[CFG_ABITS]);

    // Reset gates the accepts so the RAM never sees an enable while held.
    assign w_push_acc = reset_n_i && bus.push_i && !w_full;
    assign w_pop_acc  = reset_n_i && bus.pop_i  && !w_empty;

    assign w_wdata = bus.wdata_i;
    assign w_rdata = bus.ram_rdata_i;

    assign bus.full_o        = w_full;
    assign bus.empty_o       = w_empty;
    assign bus.count_o       = w_count;
    assign bus.almost_full_o = (w_count >= C_AFULL_LVL);

    assign bus.ram_wen_o   = w_push_acc;
    assign bus.ram_be_o    = {2{w_push_acc}};
    assign bus.ram_waddr_o = r_wr_ptr[CFG_ABITS-1:0];
    assign bus.ram_wdata_o = w_wdata;

    assign bus.ram_ren_o   = w_pop_acc;
    assign bus.ram_raddr_o = r_rd_ptr[CFG_ABITS-1:0];
    assign bus.rdata_o     = w_rdata;
    // A read already in flight when reset arrives is suppressed immediately.
    assign bus.rvalid_o    = r_rvalid && reset_n_i;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_rvalid <= w_pop_acc;
        end
    end

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push_i && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop_i && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// ============================================================================
// Module      : tb_bram_sdp_fifo_ctrl
// Description : Scoreboard bench for bram_sdp_fifo_ctrl with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_sdp_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 18;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_sdp_fifo_ctrl_if #(.CFG_ABITS(AW), .CFG_DBITS(DW)) bus ();

    bram_sdp_fifo_ctrl #(
        .CFG_ABITS   (AW),
        .CFG_DBITS   (DW),
        .AFULL_THRESH(AFT)
    ) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    // Behavioural SDP RAM with per-half byte enables and 1-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_wen_o) begin
            if (bus.ram_be_o[0]) mem[bus.ram_waddr_o][8:0]  <= bus.ram_wdata_o[8:0];
            if (bus.ram_be_o[1]) mem[bus.ram_waddr_o][17:9] <= bus.ram_wdata_o[17:9];
        end
        if (bus.ram_ren_o) ram_q <= mem[bus.ram_raddr_o];
    end
    assign bus.ram_rdata_i = ram_q;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    int  wr_total = 0;
    int  rd_total = 0;
    bit  m_ovf    = 0;
    bit  m_unf    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input int sz);
        chk("count", 32'(bus.count_o), sz);
        chk("empty", 32'(bus.empty_o), (sz == 0) ? 1 : 0);
        chk("full", 32'(bus.full_o), (sz == DEPTH) ? 1 : 0);
        chk("almost_full", 32'(bus.almost_full_o), (sz >= AFT) ? 1 : 0);
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow_o), 32'(m_unf));
`endif
    endtask

    // One clock of stimulus; checks the combinational outputs and advances the model
    task automatic cycle(input bit push, input bit pop, input logic [DW-1:0] d);
        bit ep;
        bit eq;
        int sz;
        @(posedge clk);
        #1;
        bus.push_i  = push;
        bus.pop_i   = pop;
        bus.wdata_i = d;
        sz = model_q.size();
        ep = push && (sz < DEPTH);
        eq = pop && (sz > 0);
        @(negedge clk);
        check_status(sz);
        chk("ram_wen", 32'(bus.ram_wen_o), 32'(ep));
        chk("ram_be", 32'(bus.ram_be_o), ep ? 3 : 0);
        chk("ram_ren", 32'(bus.ram_ren_o), 32'(eq));
        if (ep) begin
            chk("ram_waddr", 32'(bus.ram_waddr_o), wr_total % DEPTH);
            chk("ram_wdata", 32'(bus.ram_wdata_o), 32'(d));
        end
        if (eq) begin
            chk("ram_raddr", 32'(bus.ram_raddr_o), rd_total % DEPTH);
            exp_q.push_back(model_q.pop_front());
            rd_total++;
        end
        if (ep) begin
            model_q.push_back(d);
            wr_total++;
        end
        if (push && sz == DEPTH) m_ovf = 1;
        if (pop && sz == 0) m_unf = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.push_i  = 1'b1;
        bus.pop_i   = 1'b1;
        bus.wdata_i = DW'($urandom);
        @(negedge clk);
        chk("rst_rvalid", 32'(bus.rvalid_o), 0);
        chk("rst_ram_wen", 32'(bus.ram_wen_o), 0);
        chk("rst_ram_ren", 32'(bus.ram_ren_o), 0);
        @(posedge clk);
        #1;
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
        rst_n      = 1'b1;
        model_q.delete();
        exp_q.delete();
        wr_total = 0;
        rd_total = 0;
        m_ovf    = 0;
        m_unf    = 0;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(bus.rvalid_o), 0);
        check_status(0);
    endtask

    // Monitor: every rvalid must match the oldest outstanding pop
    always @(negedge clk) begin
        if (bus.rvalid_o) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rvalid: got unexpected word 0x%0h, expected no valid (t=%0t)",
                         bus.rdata_o, $time);
            end else begin
                chk("rdata", 32'(bus.rdata_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.wdata_i = '0;
        do_reset();

        // Fill, push while full, then drain back-to-back
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i));
        cycle(1, 0, DW'(18'h3ABCD));
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0);
        cycle(0, 0, '0);

        // Steady state at 8 with simultaneous push/pop across several wraps
        for (int i = 0; i < 8; i++) cycle(1, 0, DW'($urandom));
        for (int i = 0; i < 40; i++) cycle(1, 1, DW'($urandom));
        while (model_q.size() > 0) cycle(0, 1, '0);
        cycle(0, 0, '0);

        // Push and pop on an empty FIFO
        cycle(1, 1, DW'(18'h15A5A));
        cycle(0, 0, '0);
        cycle(0, 1, '0);
        cycle(0, 0, '0);

        // Randomized traffic with shifting push/pop bias
        for (int seg = 0; seg < 4; seg++) begin
            int pp;
            int pq;
            pp = (seg == 0) ? 85 : (seg == 1) ? 25 : (seg == 2) ? 50 : 95;
            pq = (seg == 0) ? 30 : (seg == 1) ? 85 : (seg == 2) ? 50 : 60;
            for (int i = 0; i < 120; i++) begin
                cycle($urandom_range(99) < pp, $urandom_range(99) < pq, DW'($urandom));
            end
        end

        // Pop in flight when reset asserts
        cycle(1, 0, DW'(18'h2F0F0));
        cycle(1, 0, DW'(18'h10F0F));
        cycle(0, 1, '0);
        do_reset();
        cycle(0, 0, '0);
        cycle(0, 1, '0);
        cycle(0, 0, '0);

        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
